// File: rtl/sub16s_rr_sched.sv
// Round-robin scheduler sharing one 16-bit signed subtractor between NREQ requesters.
// Optional build macro SUB16S_SAT_EN: saturate rsp_result on overflow instead of wrapping.
module sub16s_rr_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_result,
    output logic                 rsp_overflow,
    input  logic                 cnt_clr,
    output logic [15:0]          op_cnt,
    output logic [7:0]           ovf_cnt
);

    localparam int unsigned DW = 16;
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW:0]     cand;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic             fire;
    logic [DW-1:0]    a_sel;
    logic [DW-1:0]    b_sel;
    logic [DW:0]      diff;
    logic             ovf_c;
    logic [DW-1:0]    res_c;
    logic [IDW-1:0]   ptr_nxt;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    assign accept = (state == EMPTY) | rsp_ready;
    assign fire   = accept & grant_found;

    // req_ready is forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (fire && rst_n) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign a_sel = req_a[{grant_idx, 4'b0000} +: DW];
    assign b_sel = req_b[{grant_idx, 4'b0000} +: DW];
    assign diff  = {a_sel[DW-1], a_sel} - {b_sel[DW-1], b_sel};
    assign ovf_c = diff[DW] ^ diff[DW-1];

`ifdef SUB16S_SAT_EN
    assign res_c = ovf_c ? (diff[DW] ? 16'h8000 : 16'h7FFF) : diff[DW-1:0];
`else
    assign res_c = diff[DW-1:0];
`endif

    assign ptr_nxt   = (grant_idx == LAST_ID) ? '0 : grant_idx + IDW'(1);
    assign rsp_valid = (state == FULL);

    // Output stage: load on accept, drain to EMPTY when consumed with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            ptr          <= '0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            if (fire) begin
                state        <= FULL;
                ptr          <= ptr_nxt;
                rsp_id       <= grant_idx;
                rsp_result   <= res_c;
                rsp_overflow <= ovf_c;
            end else if (state == FULL && rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

    // Saturating debug counters; clear wins over a coincident accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt  <= '0;
            ovf_cnt <= '0;
        end else if (cnt_clr) begin
            op_cnt  <= '0;
            ovf_cnt <= '0;
        end else if (fire) begin
            if (op_cnt != 16'hFFFF) begin
                op_cnt <= op_cnt + 16'd1;
            end
            if (ovf_c && ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/sub16s_rr_sched.md
# sub16s_rr_sched

Round-robin scheduler that shares one 16-bit signed subtractor (result = A − B, two's complement, with overflow flag) between NREQ requesters. Each requester presents an operand pair under a valid/ready handshake. The scheduler grants one request per cycle and registers the difference with its requester ID. It holds the result on a single-entry output stage under rsp_valid/rsp_ready backpressure. It sits between the requesting datapath lanes and any consumer of signed differences, and also keeps saturating operation and overflow counters for debug.

## Interface
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: requester ID width, equal to clog2(NREQ) with a minimum of 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  bit i: requester i has an operand pair.
- req_ready  out  NREQ  bit i: requester i's pair is accepted this cycle. At most one bit is high.
- req_a  in  16*NREQ  signed minuend; lane i occupies bits [16i+15:16i].
- req_b  in  16*NREQ  signed subtrahend; same packing as req_a.
- rsp_valid  out  1  output register holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  requester index of the held result.
- rsp_result  out  16  signed difference.
- rsp_overflow  out  1  the exact difference does not fit in 16 bits.
- cnt_clr  in  1  synchronous clear of both counters.
- op_cnt  out  16  count of accepted operations, saturates at 0xFFFF.
- ovf_cnt  out  8  count of accepted operations that overflowed, saturates at 0xFF.

## Operation
- The output stage has two states:
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
- Accept condition: accept = (state == EMPTY) | rsp_ready.
  - rsp_ready is only meaningful in FULL.
  - In EMPTY, rsp_ready is ignored.
- Arbitration:
  - Search req_valid starting at index ptr and wrapping modulo NREQ.
  - The first set bit is granted, index g.
  - req_ready[g] = accept & req_valid[g]. All other req_ready bits are 0.
  - req_ready is combinational from req_valid, ptr, state and rsp_ready.
- When a request is accepted:
  - Output register loads rsp_id = g, rsp_result, and rsp_overflow.
  - Next state is FULL.
  - ptr ← (g+1) mod NREQ.
- When nothing is accepted: ptr is unchanged.
- In FULL with rsp_ready = 1 and no request: next state is EMPTY.
- In FULL with rsp_ready = 0:
  - The output register holds stable.
  - All req_ready bits are 0.
- Arithmetic:
  - d = sign-extend-17(A) − sign-extend-17(B).
  - rsp_result = d[15:0].
  - rsp_overflow = d[16] ^ d[15].
  - This flags B = 0x8000 correctly, e.g. 0 − (−32768).
- Counters:
  - On each accept, op_cnt increments by 1 (saturating).
  - On each accept with overflow, ovf_cnt increments by 1 (saturating).
  - cnt_clr has priority: if cnt_clr and an accept occur in the same cycle, both counters become 0 and that operation is not counted.
- Requesters may drop req_valid at any time without penalty. No request is latched until it is accepted.

## Timing
- Reset values, applied asynchronously while rst_n = 0:
  - State: EMPTY.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_overflow = 0.
  - ptr = 0.
  - op_cnt = 0, ovf_cnt = 0.
  - req_ready = 0.
- Reset asserted mid-operation discards any held result and returns the arbitration pointer to 0.
- Latency: a request accepted at edge N is presented with rsp_valid = 1 after edge N, i.e. one cycle.
- Throughput: one operation per cycle while rsp_ready = 1.
- Back-to-back transfer: in FULL, a result is drained and a new request is accepted on the same edge.
- Fairness:
  - With all NREQ requesters continuously valid and rsp_ready = 1, grants cycle 0, 1, …, NREQ−1, 0, …
  - No requester waits more than NREQ−1 accepts.
- Counters update on the same edge as the accept. Their values are visible the following cycle.

## Configuration
- SUB16S_SAT_EN:
  - Defined: on overflow, rsp_result saturates to 0x7FFF if d is positive (d[16] = 0), or to 0x8000 if d is negative. rsp_overflow is still asserted.
  - Undefined: rsp_result is the wrapped d[15:0].
- Counters, rsp_overflow and handshake behaviour are identical in both builds.

## Test plan
- Reset, then a single request on lane 2 with A = 100, B = 300:
  - One cycle later: rsp_valid = 1, rsp_id = 2, rsp_result = 0xFF38 (−200), rsp_overflow = 0.
  - op_cnt = 1.
- All four lanes valid continuously, rsp_ready = 1, run 8 cycles:
  - Grant order is 0, 1, 2, 3, 0, 1, 2, 3.
  - Exactly one req_ready bit is high per cycle.
- Overflow cases:
  - A = 0x7FFF, B = 0xFFFF: result 0x8000 with overflow = 1 (SAT_EN: 0x7FFF, overflow = 1).
  - A = 0, B = 0x8000: result 0x8000 with overflow = 1 (SAT_EN: 0x7FFF, overflow = 1).
  - A = 0x8000, B = 1: result 0x7FFF with overflow = 1 (SAT_EN: 0x8000, overflow = 1).
  - ovf_cnt increments by 3 in total.
- Backpressure:
  - Result held with rsp_ready = 0 for 5 cycles while lanes 0 and 1 are valid.
  - All req_ready stay 0 and rsp fields stay stable.
  - Raise rsp_ready: lane 0 (or lane ptr) is accepted on the same edge the old result drains.
- Counter limits:
  - Drive 70000 accepts: op_cnt holds at 0xFFFF.
  - Assert cnt_clr coincident with an overflowing accept: both counters read 0 next cycle.
- Reset mid-operation:
  - Drop rst_n while FULL with ptr = 3.
  - rsp_valid goes to 0 immediately.
  - After release, with all lanes valid, the first grant goes to lane 0.
